// File: rtl/header_receiver_pkg.sv
// Shared definitions for the header receiver: defaults, response codes,
// FSM encodings and small arithmetic helpers.
package header_receiver_pkg;

    localparam int         DEF_HEADER_BYTES   = 80;
    localparam logic [7:0] DEF_SYNC_BYTE      = 8'hAA;
    localparam int         DEF_TIMEOUT_CYCLES = 5_000_000;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/header_receiver_if.sv
// Byte-stream input, header handoff and ack/statistics bundle of the header receiver.
interface header_receiver_if import header_receiver_pkg::*; #(
    parameter int HEADER_BYTES = DEF_HEADER_BYTES
);
    logic [7:0]                rx_data;
    logic                      rx_valid;
    logic                      rx_error;
    logic [8*HEADER_BYTES-1:0] header;
    logic                      header_valid;
    logic                      header_ready;
    logic [7:0]                ack_data;
    logic                      ack_valid;
    logic [15:0]               frame_count;
    logic [15:0]               error_count;

    modport slave (
        input  rx_data, rx_valid, rx_error, header_ready,
        output header, header_valid, ack_data, ack_valid, frame_count, error_count
    );

    modport master (
        output rx_data, rx_valid, rx_error, header_ready,
        input  header, header_valid, ack_data, ack_valid, frame_count, error_count
    );
endinterface

// File: rtl/header_receiver_inter_byte_timer.sv
// Idle-gap timer: counts ticks since the last load and flags when the limit is hit.
module inter_byte_timer import header_receiver_pkg::*; #(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic expired
);
    localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] count_r;

    // Saturating gap counter, cleared by load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= '0;
        end else if (tick && (count_r != LIMIT)) begin
            count_r <= count_r + TW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LIMIT);

endmodule

// File: rtl/header_receiver.sv
// Frames a sync-prefixed byte stream into a fixed-length header, verifies the
// XOR checksum, acknowledges the sender and holds the header until accepted.
module header_receiver import header_receiver_pkg::*; #(
    parameter int         HEADER_BYTES   = DEF_HEADER_BYTES,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    header_receiver_if.slave bus
);
    localparam int            HW        = 8 * HEADER_BYTES;
    localparam int            BW        = $clog2(HEADER_BYTES + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(HEADER_BYTES - 1);

    state_t          state_r;
    logic [BW-1:0]   byte_cnt_r;
    logic [7:0]      xor_r;
    logic [HW-1:0]   header_r;
    logic            header_valid_r;
    logic [7:0]      ack_data_r;
    logic            ack_valid_r;
    logic [15:0]     frame_count_r;
    logic [15:0]     error_count_r;

    logic            in_frame_s;
    logic            byte_s;
    logic            abort_s;
    logic            expired_s;
    logic            timer_load_s;

    // Event decode; a framing error always beats a simultaneous byte
    always_comb begin
        in_frame_s   = (state_r == ST_LOAD) || (state_r == ST_CHECK);
        byte_s       = bus.rx_valid && !bus.rx_error;
        abort_s      = in_frame_s && (bus.rx_error || (expired_s && !bus.rx_valid));
        timer_load_s = bus.rx_valid || !in_frame_s;
    end

    inter_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load_s),
        .tick    (in_frame_s),
        .expired (expired_s)
    );

    // Frame FSM with header shift register, checksum and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            byte_cnt_r     <= '0;
            xor_r          <= 8'h00;
            header_r       <= '0;
            header_valid_r <= 1'b0;
            ack_data_r     <= 8'h00;
            ack_valid_r    <= 1'b0;
            frame_count_r  <= 16'h0000;
            error_count_r  <= 16'h0000;
        end else begin
            ack_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (byte_s && (bus.rx_data == SYNC_BYTE)) begin
                        state_r    <= ST_LOAD;
                        byte_cnt_r <= '0;
                        xor_r      <= 8'h00;
                    end
                end
                ST_LOAD: begin
                    if (abort_s) begin
                        state_r       <= ST_IDLE;
                        error_count_r <= sat_inc16(error_count_r);
                    end else if (byte_s) begin
                        header_r <= {header_r[HW-9:0], bus.rx_data};
                        xor_r    <= xor_r ^ bus.rx_data;
                        if (byte_cnt_r == LAST_BYTE) begin
                            state_r    <= ST_CHECK;
                            byte_cnt_r <= '0;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + BW'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (abort_s) begin
                        state_r       <= ST_IDLE;
                        error_count_r <= sat_inc16(error_count_r);
                    end else if (byte_s) begin
                        ack_valid_r <= 1'b1;
                        if (bus.rx_data == xor_r) begin
                            state_r        <= ST_HOLD;
                            header_valid_r <= 1'b1;
                            ack_data_r     <= ACK;
                            frame_count_r  <= sat_inc16(frame_count_r);
                        end else begin
                            state_r       <= ST_IDLE;
                            ack_data_r    <= NAK;
                            error_count_r <= sat_inc16(error_count_r);
                        end
                    end
                end
                ST_HOLD: begin
                    // Input traffic is deliberately ignored until the header is taken
                    if (header_valid_r && bus.header_ready) begin
                        state_r        <= ST_IDLE;
                        header_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    header_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.header       = header_r;
    assign bus.header_valid = header_valid_r;
    assign bus.ack_data     = ack_data_r;
    assign bus.ack_valid    = ack_valid_r;
    assign bus.frame_count  = frame_count_r;
    assign bus.error_count  = error_count_r;

endmodule

// File: tb/tb_header_receiver.sv
// Directed scoreboard bench for header_receiver: expected acks and headers are
// queued at stimulus time and consumed by an independent output monitor.
module tb_header_receiver;
    import header_receiver_pkg::*;

    localparam int HB = 80;
    localparam int HW = 8 * HB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    header_receiver_if #(.HEADER_BYTES(HB)) bus ();

    header_receiver #(
        .HEADER_BYTES   (HB),
        .SYNC_BYTE      (8'hAA),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_fc = 0;
    int exp_ec = 0;
    logic [7:0]    ack_q[$];
    logic [HW-1:0] hdr_q[$];
    logic [7:0]    fr[HB];
    logic          hv_prev = 1'b0;

    task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Output monitor: every ack pulse and every rising header_valid must be expected
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ack_valid) begin
                if (ack_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got %0h want none", bus.ack_data);
                end else begin
                    check("ack_data", HW'(bus.ack_data), HW'(ack_q.pop_front()));
                end
            end
            if (bus.header_valid && !hv_prev) begin
                if (hdr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_header_valid: got 1 want 0");
                end else begin
                    check("header", bus.header, hdr_q.pop_front());
                end
            end
        end
        hv_prev = bus.header_valid;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic err);
        @(negedge clk);
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        bus.rx_error = err;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
    endtask

    task automatic fill_default();
        for (int i = 0; i < HB; i++) fr[i] = 8'(i);
    endtask

    function automatic logic [HW-1:0] pack_frame();
        logic [HW-1:0] r;
        r = '0;
        for (int i = 0; i < HB; i++) r = {r[HW-9:0], fr[i]};
        return r;
    endfunction

    task automatic send_frame(input logic [7:0] chk, input logic good);
        if (good) begin
            ack_q.push_back(ACK);
            hdr_q.push_back(pack_frame());
            exp_fc++;
        end else begin
            ack_q.push_back(NAK);
            exp_ec++;
        end
        send(8'hAA, 1'b0);
        for (int i = 0; i < HB; i++) send(fr[i], 1'b0);
        send(chk, 1'b0);
    endtask

    task automatic release_hold();
        @(negedge clk);
        bus.header_ready = 1'b1;
        @(negedge clk);
        bus.header_ready = 1'b0;
        check("hv_after_ready", HW'(bus.header_valid), HW'(1'b0));
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_count"}, HW'(bus.frame_count), HW'(exp_fc));
        check({tag, "_error_count"}, HW'(bus.error_count), HW'(exp_ec));
    endtask

    initial begin
        bus.rx_data      = 8'h00;
        bus.rx_valid     = 1'b0;
        bus.rx_error     = 1'b0;
        bus.header_ready = 1'b0;
        cycles(3);
        check("rst_header", bus.header, '0);
        check("rst_hv", HW'(bus.header_valid), HW'(1'b0));
        check("rst_ack_data", HW'(bus.ack_data), HW'(8'h00));
        check("rst_ack_valid", HW'(bus.ack_valid), HW'(1'b0));
        check_counts("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Good frame 00..4F, checksum 00; hold with ready low while traffic is ignored
        fill_default();
        send_frame(8'h00, 1'b1);
        cycles(2);
        check("a_hv", HW'(bus.header_valid), HW'(1'b1));
        check("a_first_byte", HW'(bus.header[639:632]), HW'(8'h00));
        check("a_last_byte", HW'(bus.header[7:0]), HW'(8'h4F));
        check_counts("a");
        send(8'hAA, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        cycles(94);
        check("a_hv_held", HW'(bus.header_valid), HW'(1'b1));
        check("a_header_stable", HW'(bus.header[7:0]), HW'(8'h4F));
        check_counts("a_hold");
        release_hold();

        // Bad checksum
        send_frame(8'h01, 1'b0);
        cycles(2);
        check("b_hv", HW'(bus.header_valid), HW'(1'b0));
        check_counts("b");

        // Error strobe while idle is ignored
        send(8'h00, 1'b1);
        cycles(2);
        check_counts("idle_err");

        // Timeout after 40 bytes, then a good frame
        send(8'hAA, 1'b0);
        for (int i = 0; i < 40; i++) send(fr[i], 1'b0);
        cycles(1100);
        exp_ec++;
        check_counts("timeout");
        send_frame(8'h00, 1'b1);
        cycles(2);
        check_counts("c_after");
        release_hold();

        // Error with byte 20, then 55 garbage before a good frame
        send(8'hAA, 1'b0);
        for (int i = 0; i < 20; i++) send(fr[i], 1'b0);
        send(fr[20], 1'b1);
        cycles(2);
        exp_ec++;
        check_counts("rx_err");
        send(8'h55, 1'b0);
        send_frame(8'h00, 1'b1);
        cycles(2);
        check("d_first_byte", HW'(bus.header[639:632]), HW'(8'h00));
        check_counts("d_after");
        release_hold();

        // Sync value as data at byte 10: checksum 0A^AA = A0
        fr[10] = 8'hAA;
        send_frame(8'hA0, 1'b1);
        cycles(2);
        check("e_byte10", HW'(bus.header[559:552]), HW'(8'hAA));
        check_counts("e");
        release_hold();
        fill_default();

        // Reset mid-frame at byte 50
        send(8'hAA, 1'b0);
        for (int i = 0; i < 50; i++) send(fr[i], 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_fc = 0;
        exp_ec = 0;
        check("f_header", bus.header, '0);
        check("f_hv", HW'(bus.header_valid), HW'(1'b0));
        check("f_ack_data", HW'(bus.ack_data), HW'(8'h00));
        check("f_ack_valid", HW'(bus.ack_valid), HW'(1'b0));
        check_counts("f_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h00, 1'b1);
        cycles(2);
        check_counts("f_after");
        release_hold();

        cycles(5);
        check("ack_q_empty", HW'(ack_q.size()), HW'(0));
        check("hdr_q_empty", HW'(hdr_q.size()), HW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
